// File: rtl/sme_match_collector_if.sv
// Handshake bundle between the SME match port, the collector and the core-side stream.
// master drives SME results and core ready; slave is the collector.
interface sme_match_collector_if;
    logic        pkt_start;
    logic        pkt_done;
    logic [15:0] match_rule_ID;
    logic        match_valid;
    logic        match_release;
    logic        reload;
    logic [15:0] m_axis_tdata;
    logic        m_axis_tvalid;
    logic        m_axis_tlast;
    logic        m_axis_tready;
    logic        busy;

    modport master (
        output pkt_start, pkt_done, match_rule_ID, match_valid, m_axis_tready,
        input  match_release, reload, m_axis_tdata, m_axis_tvalid, m_axis_tlast, busy
    );

    modport slave (
        input  pkt_start, pkt_done, match_rule_ID, match_valid, m_axis_tready,
        output match_release, reload, m_axis_tdata, m_axis_tvalid, m_axis_tlast, busy
    );
endinterface

// File: rtl/sme_match_collector.sv
// Drains per-packet SME matches into a rule-ID stream closed by a summary word, then re-arms the SME.
// One-cycle capture-to-beat latency; captures stall (no release) while the output register holds an unaccepted beat.
module sme_match_collector #(
    parameter int MAX_MATCHES  = 16,
    parameter int DRAIN_CYCLES = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    sme_match_collector_if.slave  io
);
    localparam int              IW        = $clog2(DRAIN_CYCLES + 1);
    localparam logic [IW-1:0]   DRAIN_LIM = IW'(DRAIN_CYCLES);
    localparam logic [14:0]     CNT_MAX   = 15'h7FFF;

    typedef enum logic [2:0] {IDLE, ACTIVE, HOLD, FINISH, RELOAD} state_t;

    state_t        state;
    logic [14:0]   count;
    logic          overflow;
    logic          done_seen;
    logic          hold_cnt;
    logic [IW-1:0] idle_cnt;
    logic          can_load;
    logic          cnt_full;

    assign can_load = !io.m_axis_tvalid || io.m_axis_tready;
    assign cnt_full = int'(count) >= MAX_MATCHES;
    assign io.busy  = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= IDLE;
            count            <= '0;
            overflow         <= 1'b0;
            done_seen        <= 1'b0;
            hold_cnt         <= 1'b0;
            idle_cnt         <= '0;
            io.match_release <= 1'b0;
            io.reload        <= 1'b0;
            io.m_axis_tvalid <= 1'b0;
            io.m_axis_tlast  <= 1'b0;
            io.m_axis_tdata  <= '0;
        end else begin
            io.match_release <= 1'b0;
            io.reload        <= 1'b0;
            if (io.m_axis_tvalid && io.m_axis_tready)
                io.m_axis_tvalid <= 1'b0;
            if (state != IDLE && io.pkt_done)
                done_seen <= 1'b1;

            case (state)
                IDLE: begin
                    if (io.pkt_start) begin
                        state     <= ACTIVE;
                        count     <= '0;
                        overflow  <= 1'b0;
                        done_seen <= io.pkt_done;
                        idle_cnt  <= '0;
                    end
                end
                ACTIVE: begin
                    if (io.match_valid) begin
                        // A pending match always beats the drain timeout.
                        idle_cnt <= '0;
                        if (cnt_full || can_load) begin
                            io.match_release <= 1'b1;
                            if (cnt_full) begin
                                overflow <= 1'b1;
                            end else begin
                                io.m_axis_tvalid <= 1'b1;
                                io.m_axis_tlast  <= 1'b0;
                                io.m_axis_tdata  <= io.match_rule_ID;
                            end
                            if (count != CNT_MAX)
                                count <= count + 15'd1;
                            hold_cnt <= 1'b0;
                            state    <= HOLD;
                        end
                    end else if (!done_seen) begin
                        idle_cnt <= '0;
                    end else if (idle_cnt == DRAIN_LIM) begin
                        state <= FINISH;
                    end else begin
                        idle_cnt <= idle_cnt + IW'(1);
                    end
                end
                HOLD: begin
                    // match_valid is stale until the SME mask catches up with the release.
                    idle_cnt <= '0;
                    hold_cnt <= 1'b1;
                    if (hold_cnt)
                        state <= ACTIVE;
                end
                FINISH: begin
                    if (io.m_axis_tvalid && io.m_axis_tlast) begin
                        if (io.m_axis_tready) begin
                            state     <= RELOAD;
                            io.reload <= 1'b1;
                        end
                    end else if (can_load) begin
                        io.m_axis_tvalid <= 1'b1;
                        io.m_axis_tlast  <= 1'b1;
                        io.m_axis_tdata  <= {overflow, count};
                    end
                end
                RELOAD: begin
                    io.m_axis_tlast <= 1'b0;
                    state           <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
